// File: rtl/program_counter_unit.sv
// Fetch-path program counter: boot/run/halt control, stall, aligned branch redirect, wrap flag.
// Define PC_RAS_EN to compile in the circular return-address stack (call/ret).
module program_counter_unit #(
    parameter int unsigned      WIDTH        = 64,
    parameter int unsigned      INCREMENT    = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             branch_valid,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             wrap,
    output logic             align_fault,
    output logic             ras_underflow
);

    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INCREMENT - 1);
    localparam logic [WIDTH:0]   STEP     = (WIDTH + 1)'(INCREMENT);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalted
    } state_e;

    state_e r_state;

    // Extra top bit captures the carry out of the sequential increment.
    logic [WIDTH:0]   w_inc;
    logic [WIDTH-1:0] w_target_aligned;
    logic             w_misaligned;
    logic             w_pop;
    logic             w_underflow;
    logic [WIDTH-1:0] w_ras_top;

    assign w_inc            = {1'b0, pc} + STEP;
    assign w_target_aligned = branch_target & ~LOW_MASK;
    assign w_misaligned     = |(branch_target & LOW_MASK);

`ifdef PC_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_ras_ptr;  // next free slot; top of stack sits just below it
    logic [CNT_W-1:0] r_ras_cnt;

    logic             w_run_act;
    logic             w_push;
    logic             w_pop_req;
    logic             w_ras_empty;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_ptr_dec;

    assign w_run_act   = (r_state == StRun) && !halt_req;
    assign w_push      = w_run_act && branch_valid && call;
    assign w_pop_req   = w_run_act && !branch_valid && ret;
    assign w_ras_empty = (r_ras_cnt == '0);
    assign w_pop       = w_pop_req && !w_ras_empty;
    assign w_underflow = w_pop_req && w_ras_empty;
    assign w_ptr_inc   = (r_ras_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_ras_ptr + 1'b1;
    assign w_ptr_dec   = (r_ras_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : r_ras_ptr - 1'b1;
    assign w_ras_top   = r_ras[w_ptr_dec];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ras_ptr     <= '0;
            r_ras_cnt     <= '0;
            ras_underflow <= 1'b0;
        end else begin
            ras_underflow <= w_underflow;
            if (w_push) begin
                r_ras_ptr <= w_ptr_inc;
                // A full stack overwrites its oldest entry, so the count saturates.
                if (r_ras_cnt != CNT_W'(RAS_DEPTH)) begin
                    r_ras_cnt <= r_ras_cnt + 1'b1;
                end
            end else if (w_pop) begin
                r_ras_ptr <= w_ptr_dec;
                r_ras_cnt <= r_ras_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_ras[r_ras_ptr] <= w_inc[WIDTH-1:0];
        end
    end
`else
    logic w_unused;

    assign w_unused      = call ^ ret;
    assign w_pop         = 1'b0;
    assign w_underflow   = 1'b0;
    assign w_ras_top     = '0;
    assign ras_underflow = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= StBoot;
            pc          <= RESET_VECTOR;
            pc_valid    <= 1'b0;
            wrap        <= 1'b0;
            align_fault <= 1'b0;
        end else begin
            wrap        <= 1'b0;
            align_fault <= 1'b0;
            case (r_state)
                StBoot: begin
                    r_state  <= StRun;
                    pc_valid <= 1'b1;
                end
                StRun: begin
                    if (halt_req) begin
                        r_state  <= StHalted;
                        pc_valid <= 1'b0;
                    end else if (branch_valid) begin
                        pc          <= w_target_aligned;
                        align_fault <= w_misaligned;
                    end else if (w_pop) begin
                        pc <= w_ras_top;
                    end else if (!stall) begin
                        pc   <= w_inc[WIDTH-1:0];
                        wrap <= w_inc[WIDTH];
                    end
                end
                StHalted: begin
                    if (resume && !halt_req) begin
                        r_state  <= StRun;
                        pc_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= StBoot;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

    // Keeps the otherwise unused underflow wire visible in the default build.
    logic w_unused_uf;
    assign w_unused_uf = w_underflow;

endmodule
